output_port_buffer: RTL and testbench

// - Parametrised successor of the switch output stage: N-input selector feeding a DEPTH-entry FIFO.

---
 rtl/packet_pkg.sv | 14 +
 rtl/output_port_buffer_sync_fifo.sv | 67 ++++++
 rtl/output_port_buffer.sv | 103 ++++++++++
 tb/tb_output_port_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// packet_pkg: shared packet-path constants and types for the switch datapath.
//   DATA_WIDTH      full ingress word width
//   NUM_PORTS       default number of ingress inputs per output port
//   OUT_FIFO_DEPTH  default output-port FIFO depth
//   payload_t       upper half of an ingress word (the part forwarded to egress)
package packet_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int NUM_PORTS      = 4;
  localparam int OUT_FIFO_DEPTH = 4;

  typedef logic [DATA_WIDTH/2-1:0] payload_t;

endpackage : packet_pkg

// File: rtl/output_port_buffer_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO holding the storage and pointers.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   wr_en        write request (ignored when full)
//   wr_data      data written at the tail
//   rd_en        read request (ignored when empty), head advances on the edge
//   rd_data      entry at the head, '0 when empty
//   count        occupancy 0..DEPTH
//   full, empty  occupancy flags
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A full FIFO refuses writes even if a read frees a slot this cycle.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage needs no reset: rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are DEPTH-sized (power of 2) and wrap on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule : sync_fifo

// File: rtl/output_port_buffer.sv
// output_port_buffer: per-output-port selector + FIFO between the arbiter and
// the egress link. On each accepted grant the upper half of the granted ingress
// word is queued; queued payloads are replayed in order with valid/ready.
// Optional feature macro: OUTPORT_STATS_EN adds the saturating drop_cnt output.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   mux_sel      granted input index from the arbiter
//   arb_active   arbiter has a winner this cycle
//   data_in      packed ingress words, port i at data_in[i]
//   grant_ack    write accepted this cycle (combinational)
//   data_out     payload at FIFO head, 0 when empty
//   valid_out    data_out valid
//   ready_in     egress consumes when valid_out && ready_in
//   fill_level   occupancy 0..DEPTH
//   sel_err      one-cycle pulse after a grant with an out-of-range mux_sel
//   drop_cnt     (OUTPORT_STATS_EN) grants refused because full, saturating
module output_port_buffer
  import packet_pkg::*;
#(
  parameter  int NUM_PORTS  = packet_pkg::NUM_PORTS,
  parameter  int DATA_WIDTH = packet_pkg::DATA_WIDTH,
  parameter  int DEPTH      = packet_pkg::OUT_FIFO_DEPTH,
  localparam int SEL_W      = $clog2(NUM_PORTS),
  localparam int HALF_W     = DATA_WIDTH / 2,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [SEL_W-1:0]                     mux_sel,
  input  logic                                 arb_active,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_in,
  output logic                                 grant_ack,
  output logic [HALF_W-1:0]                    data_out,
  output logic                                 valid_out,
  input  logic                                 ready_in,
  output logic [CNT_W-1:0]                     fill_level,
`ifdef OUTPORT_STATS_EN
  output logic [15:0]                          drop_cnt,
`endif
  output logic                                 sel_err
);

  localparam logic [SEL_W:0] NUM_PORTS_C = (SEL_W+1)'(NUM_PORTS);

  logic              sel_ok;
  logic [HALF_W-1:0] sel_payload;
  logic              wr_en;
  logic              rd_en;
  logic              full;
  logic              empty;

  // Extra MSB so a non-power-of-2 port count can flag unused select codes.
  assign sel_ok = ({1'b0, mux_sel} < NUM_PORTS_C);

  // Only the payload half of each word is ever routed.
  always_comb begin
    sel_payload = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mux_sel == SEL_W'(i)) begin
        sel_payload = data_in[i][DATA_WIDTH-1 -: HALF_W];
      end
    end
  end

  assign wr_en     = arb_active && !full && sel_ok;
  assign grant_ack = wr_en;
  assign valid_out = !empty;
  assign rd_en     = valid_out && ready_in;

  sync_fifo #(
    .WIDTH (HALF_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (sel_payload),
    .rd_en   (rd_en),
    .rd_data (data_out),
    .count   (fill_level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= arb_active && !sel_ok;
    end
  end

`ifdef OUTPORT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (arb_active && full && sel_ok && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule : output_port_buffer

// File: tb/tb_output_port_buffer.sv
module tb_output_port_buffer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mux_sel;
  logic             arb_active;
  logic [3:0][31:0] data_in;
  logic             grant_ack;
  logic [15:0]      data_out;
  logic             valid_out;
  logic             ready_in;
  logic [2:0]       fill_level;
  logic             sel_err;
`ifdef OUTPORT_STATS_EN
  logic [15:0]      drop_cnt;
`endif

  // Second instance with 3 ports to exercise the out-of-range select code.
  logic [1:0]       mux_sel1;
  logic             arb_active1;
  logic [2:0][31:0] data_in1;
  logic             grant_ack1;
  logic [15:0]      data_out1;
  logic             valid_out1;
  logic             ready_in1;
  logic [2:0]       fill_level1;
  logic             sel_err1;
`ifdef OUTPORT_STATS_EN
  logic [15:0]      drop_cnt1;
`endif

  always #5 clk = ~clk;

  output_port_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mux_sel    (mux_sel),
    .arb_active (arb_active),
    .data_in    (data_in),
    .grant_ack  (grant_ack),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .fill_level (fill_level),
`ifdef OUTPORT_STATS_EN
    .drop_cnt   (drop_cnt),
`endif
    .sel_err    (sel_err)
  );

  output_port_buffer #(.NUM_PORTS(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .mux_sel    (mux_sel1),
    .arb_active (arb_active1),
    .data_in    (data_in1),
    .grant_ack  (grant_ack1),
    .data_out   (data_out1),
    .valid_out  (valid_out1),
    .ready_in   (ready_in1),
    .fill_level (fill_level1),
`ifdef OUTPORT_STATS_EN
    .drop_cnt   (drop_cnt1),
`endif
    .sel_err    (sel_err1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic        arb;
    logic [1:0]  sel;
    logic        ready;
    logic [15:0] payload;
    logic        exp_ack;
    logic [2:0]  exp_fill;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus against the 4-port DUT, checked with a queue model.
  // Called right after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic arb, input logic [1:0] sel, input logic rdy,
                       input logic [15:0] payload, output logic ack_seen);
    logic exp_ack;
    logic exp_rd;
    for (int p = 0; p < 4; p++) data_in[p] = $urandom();
    data_in[sel] = {payload, 16'($urandom())};
    arb_active = arb;
    mux_sel    = sel;
    ready_in   = rdy;
    #1;
    exp_ack = arb && (sb_q.size() < 4);
    exp_rd  = rdy && (sb_q.size() != 0);
    ack_seen = grant_ack;
    check("grant_ack", 32'(grant_ack), 32'(exp_ack));
    check("valid_out", 32'(valid_out), 32'(sb_q.size() != 0));
    check("data_out", 32'(data_out), (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'd0);
    check("fill_level", 32'(fill_level), 32'(sb_q.size()));
    check("sel_err_4port", 32'(sel_err), 32'd0);
    @(posedge clk);
    if (exp_rd)  void'(sb_q.pop_front());
    if (exp_ack) sb_q.push_back(payload);
    @(negedge clk);
  endtask

  logic ack;

  initial begin
    vecs[0] = '{1'b1, 2'd0, 1'b0, 16'h0001, 1'b1, 3'd1};
    vecs[1] = '{1'b1, 2'd1, 1'b0, 16'h0002, 1'b1, 3'd2};
    vecs[2] = '{1'b1, 2'd2, 1'b0, 16'h0003, 1'b1, 3'd3};
    vecs[3] = '{1'b1, 2'd3, 1'b0, 16'h0004, 1'b1, 3'd4};
    vecs[4] = '{1'b1, 2'd0, 1'b0, 16'h0005, 1'b0, 3'd4};
    vecs[5] = '{1'b0, 2'd0, 1'b1, 16'h0000, 1'b0, 3'd3};
    vecs[6] = '{1'b0, 2'd0, 1'b1, 16'h0000, 1'b0, 3'd2};
    vecs[7] = '{1'b0, 2'd0, 1'b1, 16'h0000, 1'b0, 3'd1};
    vecs[8] = '{1'b0, 2'd0, 1'b1, 16'h0000, 1'b0, 3'd0};
    vecs[9] = '{1'b0, 2'd0, 1'b1, 16'h0000, 1'b0, 3'd0};

    rst_n = 1'b0;
    mux_sel = '0; arb_active = 1'b0; data_in = '0; ready_in = 1'b0;
    mux_sel1 = '0; arb_active1 = 1'b0; data_in1 = '0; ready_in1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
`ifdef OUTPORT_STATS_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single write on port 2, visible the next cycle for one cycle.
    cycle(1'b1, 2'd2, 1'b1, 16'hABCD, ack);
    check("single_ack", 32'(ack), 32'd1);
    check("single_data", 32'(data_out), 32'h0000ABCD);
    check("single_valid", 32'(valid_out), 32'd1);
    cycle(1'b0, 2'd0, 1'b1, 16'h0000, ack);
    check("single_valid_drop", 32'(valid_out), 32'd0);
    cycle(1'b0, 2'd0, 1'b1, 16'h0000, ack);

    // Fill under back-pressure, refuse the 5th, then drain in order.
    foreach (vecs[i]) begin
      cycle(vecs[i].arb, vecs[i].sel, vecs[i].ready, vecs[i].payload, ack);
      check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      check($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(vecs[i].exp_fill));
`ifdef OUTPORT_STATS_EN
      if (i == 4) check("drop_cnt_after_full", 32'(drop_cnt), 32'd1);
`endif
    end

    // Concurrent read/write at occupancy 2; pointers wrap several times.
    cycle(1'b1, 2'd1, 1'b0, 16'h1111, ack);
    cycle(1'b1, 2'd3, 1'b0, 16'h2222, ack);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 2'(k), 1'b1, 16'h3000 + 16'(k), ack);
      check("concurrent_fill", 32'(fill_level), 32'd2);
    end
    // Drain; the model still verifies order.
    repeat (3) cycle(1'b0, 2'd0, 1'b1, 16'h0000, ack);
    check("drained_fill", 32'(fill_level), 32'd0);

    // Reset mid-burst with 3 entries queued.
    cycle(1'b1, 2'd0, 1'b0, 16'h0A0A, ack);
    cycle(1'b1, 2'd1, 1'b0, 16'h0B0B, ack);
    cycle(1'b1, 2'd2, 1'b0, 16'h0C0C, ack);
    check("pre_rst_fill", 32'(fill_level), 32'd3);
    arb_active = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_out), 32'd0);
    check("async_rst_fill", 32'(fill_level), 32'd0);
    check("async_rst_data", 32'(data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    #1;
    check("post_rst_valid", 32'(valid_out), 32'd0);
    check("post_rst_fill", 32'(fill_level), 32'd0);
    check("post_rst_data", 32'(data_out), 32'd0);
`ifdef OUTPORT_STATS_EN
    check("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(negedge clk);
    cycle(1'b0, 2'd0, 1'b1, 16'h0000, ack);

    // Invalid select on the 3-port instance.
    arb_active1 = 1'b1; mux_sel1 = 2'd3; data_in1 = {3{32'hDEAD_BEEF}};
    #1;
    check("badsel_ack", 32'(grant_ack1), 32'd0);
    @(negedge clk);
    arb_active1 = 1'b0;
    #1;
    check("badsel_err", 32'(sel_err1), 32'd1);
    check("badsel_fill", 32'(fill_level1), 32'd0);
    check("badsel_valid", 32'(valid_out1), 32'd0);
    @(negedge clk);
    check("badsel_err_pulse", 32'(sel_err1), 32'd0);
    arb_active1 = 1'b1; mux_sel1 = 2'd2; data_in1[2] = 32'h5A5A_0000;
    #1;
    check("goodsel3_ack", 32'(grant_ack1), 32'd1);
    @(negedge clk);
    arb_active1 = 1'b0;
    #1;
    check("goodsel3_err", 32'(sel_err1), 32'd0);
    check("goodsel3_data", 32'(data_out1), 32'h5A5A);
    check("goodsel3_fill", 32'(fill_level1), 32'd1);

`ifdef OUTPORT_STATS_EN
    // Saturate the drop counter with refused grants while full.
    @(negedge clk);
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'(k), 1'b0, 16'h7700 + 16'(k), ack);
    arb_active = 1'b1; mux_sel = 2'd1; ready_in = 1'b0;
    repeat (65540) @(negedge clk);
    check("drop_cnt_sat", 32'(drop_cnt), 32'h0000FFFF);
    repeat (3) @(negedge clk);
    check("drop_cnt_hold", 32'(drop_cnt), 32'h0000FFFF);
    check("sat_fill", 32'(fill_level), 32'd4);
    arb_active = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_output_port_buffer
